// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word memory accesses against a memory with a
// one-cycle registered read, doing read-modify-write for sub-word stores.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic [1:0]  reqSize_q, reqSize_d;
    logic        reqUnsigned_q, reqUnsigned_d;
    logic        reqWrite_q, reqWrite_d;
    logic [31:0] reqWdata_q, reqWdata_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;

    logic        reqMisaligned;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadValue;
    logic [31:0] mergeWord;

    always_comb begin
        reqMisaligned = 1'b0;
        case (req_size)
            SIZE_BYTE: reqMisaligned = 1'b0;
            SIZE_HALF: reqMisaligned = req_addr[0];
            SIZE_WORD: reqMisaligned = (req_addr[1:0] != 2'b00);
            default:   reqMisaligned = 1'b1;
        endcase
    end

    // Lane selection and extension of the word returned by memory (little-endian).
    always_comb begin
        laneByte = 8'h00;
        case (reqAddr_q[1:0])
            2'd0:    laneByte = mem_rdata[7:0];
            2'd1:    laneByte = mem_rdata[15:8];
            2'd2:    laneByte = mem_rdata[23:16];
            default: laneByte = mem_rdata[31:24];
        endcase
        laneHalf = reqAddr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        loadValue = 32'h0000_0000;
        case (reqSize_q)
            SIZE_BYTE: loadValue = reqUnsigned_q ? {24'h000000, laneByte}
                                                 : {{24{laneByte[7]}}, laneByte};
            SIZE_HALF: loadValue = reqUnsigned_q ? {16'h0000, laneHalf}
                                                 : {{16{laneHalf[15]}}, laneHalf};
            SIZE_WORD: loadValue = mem_rdata;
            default:   loadValue = 32'h0000_0000;
        endcase
    end

    always_comb begin
        mergeWord = mem_rdata;
        case (reqSize_q)
            SIZE_BYTE: begin
                case (reqAddr_q[1:0])
                    2'd0:    mergeWord[7:0]   = reqWdata_q[7:0];
                    2'd1:    mergeWord[15:8]  = reqWdata_q[7:0];
                    2'd2:    mergeWord[23:16] = reqWdata_q[7:0];
                    default: mergeWord[31:24] = reqWdata_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (reqAddr_q[1]) begin
                    mergeWord[31:16] = reqWdata_q[15:0];
                end else begin
                    mergeWord[15:0] = reqWdata_q[15:0];
                end
            end
            default: mergeWord = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            reqAddr_q     <= 32'h0000_0000;
            reqSize_q     <= 2'b00;
            reqUnsigned_q <= 1'b0;
            reqWrite_q    <= 1'b0;
            reqWdata_q    <= 32'h0000_0000;
            misalign_q    <= 1'b0;
            rdata_q       <= 32'h0000_0000;
            merge_q       <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            reqAddr_q     <= reqAddr_d;
            reqSize_q     <= reqSize_d;
            reqUnsigned_q <= reqUnsigned_d;
            reqWrite_q    <= reqWrite_d;
            reqWdata_q    <= reqWdata_d;
            misalign_q    <= misalign_d;
            rdata_q       <= rdata_d;
            merge_q       <= merge_d;
        end
    end

    // Word stores skip the read; misaligned requests complete without touching memory.
    always_comb begin
        state_d       = state_q;
        reqAddr_d     = reqAddr_q;
        reqSize_d     = reqSize_q;
        reqUnsigned_d = reqUnsigned_q;
        reqWrite_d    = reqWrite_q;
        reqWdata_d    = reqWdata_q;
        misalign_d    = misalign_q;
        rdata_d       = rdata_q;
        merge_d       = merge_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    reqAddr_d     = req_addr;
                    reqSize_d     = req_size;
                    reqUnsigned_d = req_unsigned;
                    reqWrite_d    = req_write;
                    reqWdata_d    = req_wdata;
                    misalign_d    = reqMisaligned;
                    rdata_d       = 32'h0000_0000;
                    merge_d       = 32'h0000_0000;
                    if (reqMisaligned) begin
                        state_d = RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (reqWrite_q) begin
                    merge_d = mergeWord;
                    state_d = WR;
                end else begin
                    rdata_d = loadValue;
                    state_d = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is gated by reset so it drops immediately even while req_valid is held.
    assign stall = ~rst & (((state_q == IDLE) & req_valid) |
                           (state_q == RD) | (state_q == CAP) | (state_q == WR));

    assign resp_valid = (state_q == RESP);
    assign misaligned = (state_q == RESP) & misalign_q;
    assign resp_rdata = rdata_q;
    assign mem_read   = (state_q == RD);
    assign mem_write  = (state_q == WR);
    assign mem_addr   = {2'b00, reqAddr_q[31:2]};
    assign mem_wdata  = (reqSize_q == SIZE_WORD) ? reqWdata_q : merge_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: req_valid  in  1  pipeline memory request present.
REQ-004 SHALL have port: req_write  in  1  1=store, 0=load.
REQ-005 SHALL have port: req_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-006 SHALL have port: req_unsigned  in  1  loads zero-extend when 1, sign-extend when 0.
REQ-007 SHALL have port: req_addr  in  32  byte address.
REQ-008 SHALL have port: req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port: stall  out  1  pipeline hold.
REQ-010 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port: misaligned  out  1  error flag, valid with resp_valid.
REQ-013 SHALL have ports to data_memory: mem_addr out 32 (word index), mem_read out 1, mem_write out 1, mem_wdata out 32, mem_rdata in 32.

Function
REQ-014 SHALL use states IDLE, RD, CAP, WR, RESP; transitions only on rising clk.
REQ-015 SHALL accept a request only in IDLE with req_valid=1, latching addr, size, unsigned, write, wdata.
REQ-016 SHALL drive stall = (IDLE and req_valid) or state in {RD, CAP, WR}; stall SHALL be 0 in RESP.
REQ-017 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=0, any size 11; on accept go directly to RESP with misaligned=1, resp_rdata=0, no mem_read/mem_write ever asserted.
REQ-018 SHALL route accepted loads and byte/half stores IDLE->RD, word stores IDLE->WR.
REQ-019 SHALL in RD assert mem_read=1 with mem_addr={2'b00, addr[31:2]}; RD->CAP unconditionally.
REQ-020 SHALL treat mem_rdata as valid only in CAP (memory has one-cycle registered read).
REQ-021 SHALL, for loads in CAP, register resp_rdata: byte lane addr[1:0], half lane addr[1], little-endian, extended per req_unsigned; word unchanged; CAP->RESP.
REQ-022 SHALL, for sub-word stores in CAP, register merge word = mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0]; CAP->WR.
REQ-023 SHALL in WR assert mem_write=1, mem_addr as REQ-019, mem_wdata = merge word (sub-word) or latched wdata (word); WR->RESP.
REQ-024 SHALL assert resp_valid=1 for exactly the RESP cycle, then RESP->IDLE; no request accepted in RESP.
REQ-025 SHALL keep mem_read, mem_write at 0 outside RD and WR respectively; mem_read and mem_write never both 1.
REQ-026 SHALL have latency from accepting edge to resp_valid: word store 2 cycles, load 3, sub-word store 4, misaligned 1.
REQ-027 SHALL ignore req_* changes after acceptance (latched copy used).
REQ-028 SHALL pass upper word-index bits unchecked; out-of-range handling belongs to data_memory.

Reset
REQ-029 SHALL on rst=1 immediately force state IDLE and stall, resp_valid, misaligned, mem_read, mem_write to 0; resp_rdata, mem_addr, mem_wdata, latches to 0.
REQ-030 SHALL abort any in-flight operation on reset; a pending sub-word store SHALL NOT write memory.
REQ-031 SHALL accept a new request in the first IDLE cycle after rst deasserts.

Verification (data_memory initialised Mem[i]=i)
REQ-032 SHALL cover: lw addr 0x14 -> mem_read in RD with mem_addr 5, resp_rdata 0x00000005 three cycles after accept.
REQ-033 SHALL cover: sw 0x123480FF to 0x20, then lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080; lh 0x22 -> 0x00001234.
REQ-034 SHALL cover: after REQ-033, sb 0xAB to 0x22 -> RD, CAP, WR sequence, mem_wdata 0x12AB80FF, lw 0x20 returns 0x12AB80FF.
REQ-035 SHALL cover: lw 0x06 and sh 0x07 -> resp_valid and misaligned one cycle after accept, resp_rdata 0, no mem strobes.
REQ-036 SHALL cover: sh 0xBEEF to 0x30 with rst pulsed during CAP -> no mem_write, stall 0, lw 0x30 returns 0x0000000C.
REQ-037 SHALL cover: back-to-back lw 0x04, lw 0x08 held by stall -> two resp pulses 0x1 then 0x2, stall low exactly in each RESP cycle.
